// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//   EX-stage branch resolution unit. Selects comparator signedness, decides
//   taken/not-taken for conditional branches, JAL and JALR, computes the
//   target and issues a registered PC redirect. Holds o_flush over the
//   wrong-path IF/ID slots (static predict-not-taken). Keeps saturating
//   branch statistics.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid, i_stall    EX instruction valid / pipeline stall
//   i_is_br/jal/jalr    instruction class (one-hot when legal)
//   i_funct3            branch condition select
//   i_br_eq, i_br_lt    comparator flags
//   i_pc, i_imm         EX PC and sign-extended immediate
//   i_rs1_data          JALR base register
//   o_br_un             to comparator: unsigned compare (combinational)
//   o_redirect/o_target registered redirect pulse and its target
//   o_flush             kill IF/ID contents
//   o_misalign          taken target not 4-byte aligned (pulse)
//   o_illegal           bad funct3 or conflicting class flags (pulse)
//   o_cnt_br            accepted legal conditional branches (saturating)
//   o_cnt_taken         taken conditional branches (saturating)
// ---------------------------------------------------------------------------
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_stall,
    input  logic             i_is_br,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic [2:0]       i_funct3,
    input  logic             i_br_eq,
    input  logic             i_br_lt,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_imm,
    input  logic [31:0]      i_rs1_data,
    output logic             o_br_un,
    output logic             o_redirect,
    output logic [31:0]      o_target,
    output logic             o_flush,
    output logic             o_misalign,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_cnt_br,
    output logic [CNT_W-1:0] o_cnt_taken
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    state_t            state_q,     state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              redirect_q,  redirect_d;
    logic [31:0]       target_q,    target_d;
    logic              misalign_q,  misalign_d;
    logic              illegal_q,   illegal_d;
    logic [CNT_W-1:0]  cnt_br_q,    cnt_br_d;
    logic [CNT_W-1:0]  cnt_taken_q, cnt_taken_d;

    logic        accept;
    logic        multi_class;
    logic        bad_funct3;
    logic        br_cond;
    logic        taken;
    logic [31:0] target;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // funct3[1] selects unsigned compare for BLTU/BGEU.
    assign o_br_un = i_funct3[1];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        redirect_d  = 1'b0;
        target_d    = target_q;
        misalign_d  = 1'b0;
        illegal_d   = 1'b0;
        cnt_br_d    = cnt_br_q;
        cnt_taken_d = cnt_taken_q;

        // Instructions arriving during FLUSH are wrong-path and never accepted.
        accept      = i_valid & ~i_stall & (state_q == ST_IDLE);
        multi_class = (i_is_br & i_is_jal) | (i_is_br & i_is_jalr) | (i_is_jal & i_is_jalr);
        bad_funct3  = i_is_br & (i_funct3[2:1] == 2'b01);

        // funct3[2] picks lt vs eq; funct3[0] inverts the sense.
        br_cond = i_funct3[2] ? (i_br_lt ^ i_funct3[0]) : (i_br_eq ^ i_funct3[0]);
        taken   = (i_is_br & br_cond) | i_is_jal | i_is_jalr;
        target  = i_is_jalr ? ((i_rs1_data + i_imm) & ~32'h1) : (i_pc + i_imm);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (multi_class | bad_funct3) begin
                        illegal_d = 1'b1;
                    end else begin
                        if (i_is_br) begin
                            cnt_br_d = sat_inc(cnt_br_q);
                        end
                        if (taken) begin
                            // Misaligned taken branches still count as taken.
                            if (i_is_br) begin
                                cnt_taken_d = sat_inc(cnt_taken_q);
                            end
                            if (target[1]) begin
                                misalign_d = 1'b1;
                            end else begin
                                redirect_d  = 1'b1;
                                target_d    = target;
                                state_d     = ST_FLUSH;
                                flush_cnt_d = FC_LOAD;
                            end
                        end
                    end
                end
            end
            ST_FLUSH: begin
                // Stalls freeze the count so the flush covers the same slots.
                if (!i_stall) begin
                    if (flush_cnt_q == FC_W'(1)) begin
                        state_d     = ST_IDLE;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            redirect_q  <= 1'b0;
            target_q    <= '0;
            misalign_q  <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_br_q    <= '0;
            cnt_taken_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            redirect_q  <= redirect_d;
            target_q    <= target_d;
            misalign_q  <= misalign_d;
            illegal_q   <= illegal_d;
            cnt_br_q    <= cnt_br_d;
            cnt_taken_q <= cnt_taken_d;
        end
    end

    assign o_redirect  = redirect_q;
    assign o_target    = target_q;
    assign o_flush     = (state_q == ST_FLUSH);
    assign o_misalign  = misalign_q;
    assign o_illegal   = illegal_q;
    assign o_cnt_br    = cnt_br_q;
    assign o_cnt_taken = cnt_taken_q;

endmodule
